tc_to_sign_magnitude: RTL and testbench



---
 rtl/tc_to_sign_magnitude.sv | 152 +++++++++++++++
 tb/tb_tc_to_sign_magnitude.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_to_sign_magnitude.sv
// tc_to_sign_magnitude: bit-serial two's-complement to sign-magnitude converter.
// Accepts one N-bit operand per in_valid/in_ready handshake, walks the N-1
// magnitude bits LSB-first (copy up to and including the first 1, invert after
// it when negative) and presents sign/magnitude/overflow behind out_valid/out_ready.
// Optional build macro TC2SM_SATURATE_EN: saturate the magnitude of -2^(N-1)
// to all ones instead of the wrapped all-zeros result.
module tc_to_sign_magnitude #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_sign,
  output logic [N-2:0] out_mag,
  output logic         out_ovf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int unsigned MW = N - 1;
  localparam int unsigned CW = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 2);
  localparam logic [N-1:0]  MIN_NEG  = {1'b1, {MW{1'b0}}};
  localparam logic [MW-1:0] MAG_ONES = '1;

`ifdef TC2SM_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [MW-1:0] shreg, shreg_nxt;
  logic [MW-1:0] acc, acc_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sgn, sgn_nxt;
  logic          ovf, ovf_nxt;
  logic          seen, seen_nxt;
  logic          obit;
  logic          in_ready_nxt, busy_nxt, out_valid_nxt;
  logic          out_sign_nxt, out_ovf_nxt;
  logic [MW-1:0] out_mag_nxt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
      ovf       <= 1'b0;
      seen      <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_mag   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      sgn       <= sgn_nxt;
      ovf       <= ovf_nxt;
      seen      <= seen_nxt;
      in_ready  <= in_ready_nxt;
      busy      <= busy_nxt;
      out_valid <= out_valid_nxt;
      out_sign  <= out_sign_nxt;
      out_mag   <= out_mag_nxt;
      out_ovf   <= out_ovf_nxt;
    end
  end

  // Next-state, serial conversion step and output updates
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    sgn_nxt       = sgn;
    ovf_nxt       = ovf;
    seen_nxt      = seen;
    obit          = 1'b0;
    in_ready_nxt  = in_ready;
    busy_nxt      = busy;
    out_valid_nxt = out_valid;
    out_sign_nxt  = out_sign;
    out_mag_nxt   = out_mag;
    out_ovf_nxt   = out_ovf;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          shreg_nxt    = in_data[MW-1:0];
          sgn_nxt      = in_data[N-1];
          ovf_nxt      = (in_data == MIN_NEG);
          cnt_nxt      = '0;
          seen_nxt     = 1'b0;
          acc_nxt      = '0;
          in_ready_nxt = 1'b0;
          busy_nxt     = 1'b1;
          state_nxt    = S_BUSY;
        end
      end

      S_BUSY: begin
        // Negative operands: bits after the first 1 are inverted
        obit      = shreg[0] ^ (sgn & seen);
        seen_nxt  = seen | (sgn & shreg[0]);
        shreg_nxt = shreg >> 1;
        acc_nxt   = (acc >> 1) | (MW'(obit) << (MW - 1));
        cnt_nxt   = cnt + CW'(1);
        if (cnt == LAST_BIT) begin
          busy_nxt      = 1'b0;
          out_valid_nxt = 1'b1;
          out_sign_nxt  = sgn;
          out_ovf_nxt   = ovf;
          out_mag_nxt   = (SAT_EN && ovf) ? MAG_ONES : acc_nxt;
          state_nxt     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
          state_nxt     = S_IDLE;
        end
      end

      default: begin
        in_ready_nxt  = 1'b1;
        busy_nxt      = 1'b0;
        out_valid_nxt = 1'b0;
        state_nxt     = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tc_to_sign_magnitude.sv
// Bench for tc_to_sign_magnitude: N=4 and N=8 instances checked against an
// arithmetic reference (sign and |value| of the operand) plus literal cases.
module tb_tc_to_sign_magnitude;

`ifdef TC2SM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [3:0] d4;
  logic       v4, ir4, os4, oo4, ov4, ordy4, b4;
  logic [2:0] om4;
  logic [7:0] d8;
  logic       v8, ir8, os8, oo8, ov8, ordy8, b8;
  logic [6:0] om8;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit b2b4 = 1'b0, b2b8 = 1'b0, rbp = 1'b0;

  tc_to_sign_magnitude #(.N(4)) u4 (
    .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4), .in_ready(ir4),
    .out_sign(os4), .out_mag(om4), .out_ovf(oo4), .out_valid(ov4),
    .out_ready(ordy4), .busy(b4)
  );

  tc_to_sign_magnitude #(.N(8)) u8 (
    .clk(clk), .rst(rst), .in_data(d8), .in_valid(v8), .in_ready(ir8),
    .out_sign(os8), .out_mag(om8), .out_ovf(oo8), .out_valid(ov8),
    .out_ready(ordy8), .busy(b8)
  );

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  function automatic int pack(input logic o, input logic s, input int m);
    return (int'(o) << 9) | (int'(s) << 8) | m;
  endfunction

  // Reference: sign and absolute value of the operand read as a signed number
  function automatic int model(input int n, input int v);
    int half, s, a, o, m;
    half = 1 << (n - 1);
    if (v >= half) begin
      s = 1;
      a = (1 << n) - v;
    end else begin
      s = 0;
      a = v;
    end
    o = (a == half) ? 1 : 0;
    m = (o == 1) ? (SAT ? half - 1 : 0) : a;
    return (o << 9) | (s << 8) | m;
  endfunction

  int q4[$], a4[$], q8[$], a8[$];
  int last4 = 0, last8 = 0;
  bit prevb4 = 1'b0, prevb8 = 1'b0;

  // Handshake bookkeeping: expected results and accept cycles
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      q4.delete(); a4.delete(); q8.delete(); a8.delete();
    end else begin
      if (ov4 && ordy4 && q4.size() > 0) begin
        void'(q4.pop_front()); void'(a4.pop_front());
      end
      if (v4 && ir4) begin
        q4.push_back(model(4, int'(d4)));
        a4.push_back(cyc + 1);
        if (b2b4 && prevb4) chk("spacing4", cyc + 1 - last4, 5);
        last4 = cyc + 1;
        prevb4 = b2b4;
      end
      if (ov8 && ordy8 && q8.size() > 0) begin
        void'(q8.pop_front()); void'(a8.pop_front());
      end
      if (v8 && ir8) begin
        q8.push_back(model(8, int'(d8)));
        a8.push_back(cyc + 1);
        if (b2b8 && prevb8) chk("spacing8", cyc + 1 - last8, 9);
        last8 = cyc + 1;
        prevb8 = b2b8;
      end
    end
  end

  logic pv4 = 1'b0, pv8 = 1'b0;

  // Compare every valid output cycle against the reference
  always @(negedge clk) begin
    if (!rst) begin
      if (ov4) begin
        if (q4.size() == 0) chk("unexpected_valid4", 1, 0);
        else begin
          chk("result4", pack(oo4, os4, int'(om4)), q4[0]);
          if (!pv4) chk("latency4", cyc - a4[0], 3);
        end
      end
      if (ov8) begin
        if (q8.size() == 0) chk("unexpected_valid8", 1, 0);
        else begin
          chk("result8", pack(oo8, os8, int'(om8)), q8[0]);
          if (!pv8) chk("latency8", cyc - a8[0], 7);
        end
      end
    end
    pv4 = ov4;
    pv8 = ov8;
  end

  // Consumer ready for the N=8 instance, randomly stalled when rbp is set
  always @(negedge clk) ordy8 = rbp ? 1'($urandom_range(0, 1)) : 1'b1;

  task automatic send(input bit w8, input int d);
    int t;
    t = 0;
    if (w8) begin d8 = 8'(d); v8 = 1'b1; end
    else    begin d4 = 4'(d); v4 = 1'b1; end
    @(negedge clk);
    while (!(w8 ? ir8 : ir4) && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    v4 = 1'b0;
    v8 = 1'b0;
  endtask

  task automatic wait_ov4(input string nm);
    int t;
    t = 0;
    @(negedge clk);
    while (!ov4 && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!ov4) chk(nm, 0, 1);
  endtask

  task automatic op4(input string nm, input int d, input int exp);
    send(1'b0, d);
    wait_ov4({nm, "_timeout"});
    chk(nm, pack(oo4, os4, int'(om4)), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input bit w8);
    int n, total, tmp, j;
    int ord[];
    n = w8 ? 8 : 4;
    total = 1 << n;
    ord = new[total];
    for (int i = 0; i < total; i++) ord[i] = i;
    for (int i = total - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
    end
    if (w8) b2b8 = 1'b1; else b2b4 = 1'b1;
    for (int i = 0; i < total; i++) send(w8, ord[i]);
    b2b4 = 1'b0;
    b2b8 = 1'b0;
    repeat (2 * n + 4) @(posedge clk);
    #1;
    chk(w8 ? "drain8" : "drain4", w8 ? q8.size() : q4.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_pulse;
    rst = 1'b1; d4 = '0; v4 = 1'b0; ordy4 = 1'b1; d8 = '0; v8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready4", int'(ir4), 1);
    chk("rst_out_valid4", int'(ov4), 0);
    chk("rst_busy4", int'(b4), 0);
    chk("rst_result4", pack(oo4, os4, int'(om4)), 0);
    chk("rst_in_ready8", int'(ir8), 1);
    chk("rst_out_valid8", int'(ov8), 0);
    chk("rst_busy8", int'(b8), 0);
    chk("rst_result8", pack(oo8, os8, int'(om8)), 0);

    // Hand-computed cases for N=4
    op4("neg6", 'b1010, 'h106);
    op4("pos7", 'b0111, 'h007);
    op4("neg1", 'b1111, 'h101);
    op4("zero", 'b0000, 'h000);
    op4("minneg", 'b1000, SAT ? 'h307 : 'h300);

    // Backpressure: result must hold and new operands be ignored
    ordy4 = 1'b0;
    send(1'b0, 'b1011);
    wait_ov4("bp_timeout");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      d4 = 4'b0110;
      v4 = ~v4;
      @(negedge clk);
      chk("bp_valid", int'(ov4), 1);
      chk("bp_in_ready", int'(ir4), 0);
      chk("bp_result", pack(oo4, os4, int'(om4)), 'h105);
    end
    v4 = 1'b0;
    ordy4 = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_release_valid", int'(ov4), 0);
    chk("bp_release_ready", int'(ir4), 1);

    // Reset in the second BUSY cycle discards the operand
    send(1'b0, 'b1101);
    chk("mid_busy", int'(b4), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", int'(ir4), 1);
    chk("mid_rst_out_valid", int'(ov4), 0);
    chk("mid_rst_busy", int'(b4), 0);
    chk("mid_rst_mag", int'(om4), 0);
    seen_pulse = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov4) seen_pulse = 1;
    end
    chk("mid_rst_no_pulse", seen_pulse, 0);

    // Exhaustive shuffled sweeps, back-to-back
    sweep(1'b0);
    sweep(1'b1);

    // Random operands with random consumer stalls
    rbp = 1'b1;
    for (int i = 0; i < 40; i++) send(1'b1, int'($urandom_range(0, 255)));
    repeat (60) @(posedge clk);
    rbp = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("drain_random8", q8.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
